// File: rtl/audio_clken_gen.sv
// audio_clken_gen: phase-accumulator clock-enable generator with per-channel config and a lock FSM
module audio_clken_gen #(
  parameter int          NUM_CLOCKS  = 2,
  parameter int          ACC_W       = 32,
  parameter logic [31:0] DEFAULT_INC = 32'h7DD4_4135,
  parameter int          LOCK_CYCLES = 1024
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_sel,
  input  logic [ACC_W-1:0]      cfg_inc,
  input  logic                  cfg_enable,
  output logic [NUM_CLOCKS-1:0] clken,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);
  localparam logic [ACC_W-1:0] DEF = DEFAULT_INC[ACC_W-1:0];
  typedef enum logic [1:0] {UNLOCKED, SETTLING, LOCKED} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic wr, wen, hit, xfer;
  logic [1:0] sel;
  logic [ACC_W-1:0] winc;
  assign xfer = cfg_valid && cfg_ready;
  assign hit = wr && (int'(sel) < NUM_CLOCKS);
  assign locked = state == LOCKED;
  // an accepted write is staged for one cycle, which is also why cfg_ready drops for it
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      cfg_ready <= 1'b0;
      wr <= 1'b0;
      sel <= '0;
      winc <= '0;
      wen <= 1'b0;
    end else begin
      cfg_ready <= !xfer;
      wr <= xfer;
      if (xfer) begin
        sel <= cfg_sel;
        winc <= cfg_inc;
        wen <= cfg_enable;
      end
    end
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state <= UNLOCKED;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == UNLOCKED || hit) begin
      state_n = SETTLING;
      cnt_n = '0;
    end else if (state == SETTLING) begin
      state_n = (cnt == 16'(LOCK_CYCLES - 1)) ? LOCKED : SETTLING;
      cnt_n = (cnt == 16'(LOCK_CYCLES - 1)) ? cnt : cnt + 16'd1;
    end
  end
  for (genvar c = 0; c < NUM_CLOCKS; c++) begin : ch
    logic [ACC_W-1:0] acc, inc;
    logic [ACC_W:0] sum;
    logic en, ck, oc;
    assign sum = {1'b0, acc} + {1'b0, inc};
    assign clken[c] = ck;
    assign outclk[c] = oc;
    always_ff @(posedge refclk or posedge rst)
      if (rst) begin
        acc <= '0;
        inc <= DEF;
        en <= 1'b1;
        ck <= 1'b0;
        oc <= 1'b0;
      end else if (wr && sel == 2'(c)) begin
        acc <= '0;
        inc <= winc;
        en <= wen;
        ck <= 1'b0;
        oc <= 1'b0;
      end else if (en) begin
        acc <= sum[ACC_W-1:0];
        ck <= sum[ACC_W];
        oc <= oc ^ sum[ACC_W];
      end
  end
endmodule

// File: tb/tb_audio_clken_gen.sv
// tb_audio_clken_gen: randomized config writes checked every cycle against a pulse-count reference model
`timescale 1ns/100ps
module tb_audio_clken_gen;
  logic refclk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_enable = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_inc = '0;
  logic cfg_ready, locked;
  logic [1:0] clken, outclk;
  int tests = 0;
  int fails = 0;
  always #5 refclk = ~refclk;
  audio_clken_gen #(.NUM_CLOCKS(2), .ACC_W(8), .DEFAULT_INC(32'h80), .LOCK_CYCLES(16)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_inc(cfg_inc), .cfg_enable(cfg_enable), .clken(clken), .outclk(outclk), .locked(locked));
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: after n accumulations of inc the channel has wrapped floor(n*inc/256) times
  int mn[2], minc[2], age, pinc;
  bit men[2], mready, pend, pen, x;
  int psel;
  function automatic int wraps(input int n, input int i);
    return (n * i) / 256;
  endfunction
  always @(posedge refclk or posedge rst)
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        mn[c] = 0;
        minc[c] = 'h80;
        men[c] = 1'b1;
      end
      age = 0;
      mready = 1'b0;
      pend = 1'b0;
    end else begin
      x = cfg_valid && mready;
      for (int c = 0; c < 2; c++)
        if (pend && psel == c) begin
          mn[c] = 0;
          minc[c] = pinc;
          men[c] = pen;
        end else if (men[c]) mn[c]++;
      if (pend && psel < 2) age = 1;
      else if (age < 1000) age++;
      pend = x;
      if (x) begin
        psel = int'(cfg_sel);
        pinc = int'(cfg_inc);
        pen = cfg_enable;
      end
      mready = !x;
    end
  always @(negedge refclk) begin
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("clken[%0d]", c), int'(clken[c]),
          int'(men[c] && mn[c] > 0 && wraps(mn[c], minc[c]) != wraps(mn[c] - 1, minc[c])));
      chk($sformatf("outclk[%0d]", c), int'(outclk[c]), int'(men[c] && wraps(mn[c], minc[c]) % 2 == 1));
    end
    chk("cfg_ready", int'(cfg_ready), int'(mready));
    chk("locked", int'(locked), int'(age >= 17));
  end
  task automatic wr(input int s, input int i, input bit e);
    @(negedge refclk);
    chk("ready_before_write", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_sel = 2'(s);
    cfg_inc = 8'(i);
    cfg_enable = e;
    @(negedge refclk);
    cfg_valid = 1'b0;
    chk("ready_after_write", int'(cfg_ready), 0);
  endtask
  task automatic count_edges(input int n, input int ch, output int pulses, output int first, output int lowlk);
    pulses = 0;
    first = 0;
    lowlk = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge refclk);
      #1;
      if (clken[ch]) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (!locked) lowlk++;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int p, f, l, lk;
    #1 rst = 1'b1;
    repeat (3) @(negedge refclk);
    chk("reset_clken", int'(clken), 0);
    chk("reset_outclk", int'(outclk), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_ready", int'(cfg_ready), 0);
    rst = 1'b0;
    lk = 0;
    p = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge refclk);
      #1;
      if (k == 1) chk("ready_first_edge", int'(cfg_ready), 1);
      if (k <= 8 && clken[0]) p++;
      if (locked && lk == 0) lk = k;
    end
    chk("lock_edge_after_release", lk, 17);
    chk("ch0_pulses_first8", p, 4);
    wr(1, 'h40, 1'b1);
    count_edges(20, 1, p, f, l);
    chk("ch1_first_pulse", f, 5);
    chk("ch1_pulses_20", p, 4);
    chk("locked_low_cycles", l, 16);
    wr(0, 'h55, 1'b0);
    count_edges(30, 0, p, f, l);
    chk("ch0_disabled_pulses", p, 0);
    chk("ch0_disabled_outclk", int'(outclk[0]), 0);
    wr(3, 'h11, 1'b1);
    count_edges(20, 1, p, f, l);
    chk("bad_sel_locked_low", l, 0);
    chk("bad_sel_ch1_pulses", p, 5);
    wr(0, 'h00, 1'b1);
    count_edges(50, 0, p, f, l);
    chk("inc0_pulses", p, 0);
    wr(0, 'hFF, 1'b1);
    count_edges(257, 0, p, f, l);
    chk("incff_pulses", p, 255);
    for (int t = 0; t < 30; t++) begin
      int h;
      @(negedge refclk);
      cfg_valid = 1'b1;
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_inc = 8'($urandom);
      cfg_enable = $urandom_range(0, 3) != 0;
      h = $urandom_range(1, 3);
      repeat (h) @(negedge refclk);
      cfg_valid = 1'b0;
      repeat ($urandom_range(0, 40)) @(negedge refclk);
    end
    wr(1, 'h33, 1'b1);
    repeat (5) @(posedge refclk);
    #2 rst = 1'b1;
    #0.5;
    chk("async_clken", int'(clken), 0);
    chk("async_outclk", int'(outclk), 0);
    chk("async_locked", int'(locked), 0);
    chk("async_ready", int'(cfg_ready), 0);
    #0.5 rst = 1'b0;
    lk = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge refclk);
      #1;
      if (locked && lk == 0) lk = k;
    end
    chk("relock_after_async_reset", lk, 17);
    repeat (5) @(negedge refclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
